// File: rtl/bus_arbiter_if.sv
// Shared-bus arbitration signals between the bus masters and bus_arbiter.
// The slave modport is the arbiter's view; the master modport is the agents' view.
interface bus_arbiter_if;
  logic [3:0] request;
  logic [3:0] grant;
  logic       begin_transactionIN;
  logic       end_transactionIN;
  logic       bus_busy;
  logic [1:0] active_master;
  logic       timeout_pulse;

  modport slave (
    input  request, begin_transactionIN, end_transactionIN,
    output grant, bus_busy, active_master, timeout_pulse
  );

  modport master (
    output request, begin_transactionIN, end_transactionIN,
    input  grant, bus_busy, active_master, timeout_pulse
  );
endinterface

// File: rtl/bus_arbiter.sv
// Four-master round-robin shared-bus arbiter with a one-cycle registered grant.
// Define BUS_ARBITER_TIMEOUT_EN to revoke a grant whose begin never arrives.
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic         clock,
  input logic         n_reset,
  bus_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_GRANT      = 2'd1;
  localparam logic [1:0] S_WAIT_BEGIN = 2'd2;
  localparam logic [1:0] S_BUSY       = 2'd3;

  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic [1:0] r_last_grant;
  logic [3:0] r_grant;
  logic [1:0] w_winner;
  logic       w_found;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    logic [1:0] v_idx;
    w_winner = r_last_grant;
    w_found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      v_idx = r_last_grant + 2'(k);
      if (!w_found && bus.request[v_idx]) begin
        w_winner = v_idx;
        w_found  = 1'b1;
      end
    end
  end

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_timeout;
  logic             w_timeout;
  logic             w_wait_expired;

  // The count reaches TIMEOUT_CYCLES-1 on this edge, i.e. TIMEOUT_CYCLES cycles after the grant.
  assign w_wait_expired = (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_timeout;
      if (r_state == S_GRANT) begin
        r_wait_cnt <= '0;
      end else if (r_state == S_WAIT_BEGIN) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.timeout_pulse = r_timeout;
`else
  assign bus.timeout_pulse = 1'b0;
`endif

  // NOTE: every variable assigned in this block gets a default first, so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
`ifdef BUS_ARBITER_TIMEOUT_EN
    w_timeout    = 1'b0;
`endif
    case (r_state)
      S_IDLE:       if (w_found) w_state_next = S_GRANT;
      S_GRANT:      w_state_next = S_WAIT_BEGIN;
      S_WAIT_BEGIN: begin
        // end wins over begin so an error-terminated transfer frees the bus.
        if (bus.end_transactionIN) begin
          w_state_next = S_IDLE;
        end else if (bus.begin_transactionIN) begin
          w_state_next = S_BUSY;
`ifdef BUS_ARBITER_TIMEOUT_EN
        end else if (w_wait_expired) begin
          w_state_next = S_IDLE;
          w_timeout    = 1'b1;
`endif
        end
      end
      S_BUSY:       if (bus.end_transactionIN) w_state_next = S_IDLE;
      default:      w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= 2'd3;
    end else begin
      r_state <= w_state_next;
      r_grant <= '0;
      if (r_state == S_IDLE && w_found) begin
        r_grant      <= 4'b0001 << w_winner;
        r_last_grant <= w_winner;
      end
    end
  end

  assign bus.grant         = r_grant;
  assign bus.bus_busy      = (r_state != S_IDLE);
  assign bus.active_master = r_last_grant;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, giving the cycles allowed from grant to begin_transactionIN when timeout is compiled in.
REQ-002 The block SHALL have port clock, input, 1, the single system clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port n_reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port request, input, 4, per-master bus request; bit i comes from master i (a DMA drives requestTransaction here).
REQ-005 The block SHALL have port grant, output, 4, one-hot grant to master i (a DMA reads it as transactionGranted).
REQ-006 The block SHALL have port begin_transactionIN, input, 1, the shared-bus begin_transaction.
REQ-007 The block SHALL have port end_transactionIN, input, 1, the shared-bus end_transaction.
REQ-008 The block SHALL have port bus_busy, output, 1, high from the grant cycle until the bus is released.
REQ-009 The block SHALL have port active_master, output, 2, index of the current/last granted master.
REQ-010 The block SHALL have port timeout_pulse, output, 1, one-cycle pulse when a grant is revoked for timeout.

Function
REQ-011 The block SHALL use a registered FSM with states IDLE, GRANT, WAIT_BEGIN and BUSY.
REQ-012 In IDLE with request != 0, the block SHALL select the winner on that edge and enter GRANT; in IDLE with request == 0 it SHALL stay in IDLE.
REQ-013 Arbitration SHALL be round-robin: search from (last_grant+1) mod 4 upward, wrapping at 3 to 0; last_grant SHALL update to the winner when entering GRANT.
REQ-014 grant SHALL equal the one-hot winner only while in GRANT (exactly one cycle) and SHALL be 0 in all other states; GRANT SHALL always go to WAIT_BEGIN.
REQ-015 Grant latency SHALL be one cycle: a request sampled in IDLE at edge N gives grant high in the cycle after edge N.
REQ-016 In WAIT_BEGIN:
  - end_transactionIN=1 SHALL go to IDLE; it has priority over begin_transactionIN, covering an error-terminated transfer.
  - begin_transactionIN=1 otherwise SHALL go to BUSY.
  - otherwise the block SHALL stay in WAIT_BEGIN (subject to REQ-024).
REQ-017 In BUSY, end_transactionIN=1 SHALL go to IDLE; begin_transactionIN SHALL be ignored.
REQ-018 After release, the block SHALL spend at least one cycle in IDLE before the next grant (minimum 1 dead cycle between transactions).
REQ-019 bus_busy SHALL be high in GRANT, WAIT_BEGIN and BUSY, and low in IDLE.
REQ-020 active_master SHALL hold last_grant in every state.
REQ-021 Request changes during GRANT, WAIT_BEGIN and BUSY SHALL NOT affect the current owner.
REQ-022 A master that drops request before its grant cycle SHALL still receive the registered grant pulse; the bus then times out or waits.

Reset
REQ-023 When n_reset=0, asynchronously:
  - state SHALL be IDLE;
  - grant, bus_busy and timeout_pulse SHALL be 0;
  - last_grant SHALL be 3, so master 0 has first priority;
  - active_master SHALL be 3;
  - the timeout counter SHALL be 0.
  Reset mid-transaction SHALL abandon ownership immediately.

Configuration
REQ-024 With BUS_ARBITER_TIMEOUT_EN defined:
  - a counter SHALL clear on entering WAIT_BEGIN and increment each cycle in WAIT_BEGIN;
  - when the counter reaches TIMEOUT_CYCLES-1 with neither begin_transactionIN nor end_transactionIN high, the block SHALL go to IDLE and pulse timeout_pulse for one cycle;
  - last_grant SHALL be kept, so the next master in rotation wins.
REQ-025 Without BUS_ARBITER_TIMEOUT_EN, no counter SHALL be built, WAIT_BEGIN SHALL wait indefinitely, and timeout_pulse SHALL be tied 0.

Verification
REQ-026 The bench SHALL cover: after reset, request=4'b1111 held -> grants in order 0,1,2,3,0; each grant is one cycle; each transaction is closed by begin then end 3 cycles later.
REQ-027 The bench SHALL cover: request=4'b0100 alone in IDLE -> grant=4'b0100 the next cycle, bus_busy=1, active_master=2; end_transactionIN -> bus_busy=0 one cycle later.
REQ-028 The bench SHALL cover: in WAIT_BEGIN, begin_transactionIN and end_transactionIN both 1 in the same cycle -> the next state is IDLE, not BUSY.
REQ-029 The bench SHALL cover: with BUS_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=16, grant master 1 with no begin -> timeout_pulse=1 exactly 16 cycles after grant; with request=4'b0011 still held, the next grant goes to master 0.
REQ-030 The bench SHALL cover: n_reset asserted low while in BUSY with no clock edge -> grant=0, bus_busy=0, active_master=3 immediately.
REQ-031 The bench SHALL cover: request toggled during BUSY -> grant stays 0 until end_transactionIN, plus the 1-cycle IDLE gap.
